gateway_req_arbiter: RTL and testbench
======================================

GATEWAY_REQ_ARBITER -- requirements
Module: gateway_req_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, giving the number of requesters sharing one gateway request port (range 2..16).
REQ-002 The block SHALL have parameter DATA_W, default 96, giving the request descriptor width in bits.
REQ-003 The block SHALL have parameter ID_W, default $clog2(N_REQ), giving the width of the requester-ID tag.
REQ-004 The block SHALL use one clock and a synchronous active-high reset (clock aclk and reset areset, listed first in the port list).
REQ-005 aclk  input  1  the clock; every flop samples on its rising edge.
REQ-006 areset  input  1  synchronous active-high reset.
REQ-007 en  input  1  grant enable; when low, no new request is accepted.
REQ-008 s_valid  input  N_REQ  per-requester request valid.
REQ-009 s_ready  output  N_REQ  per-requester request accept.
REQ-010 s_data  input  N_REQ*DATA_W  per-requester descriptors; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-011 m_valid  output  1  arbitrated request valid toward the gateway.
REQ-012 m_ready  input  1  gateway accept.
REQ-013 m_data  output  DATA_W  arbitrated descriptor.
REQ-014 m_id  output  ID_W  index of the requester that owns m_data.
REQ-015 grant_total  output  32  count of accepted requests; wraps modulo 2^32.

Function
REQ-016 The output stage SHALL be one register slot (m_valid, m_data, m_id); data moves on the input side only on an s_valid[i]&&s_ready[i] handshake and on the output side only on an m_valid&&m_ready handshake.
REQ-017 load_ok SHALL equal en && (!m_valid || m_ready), which allows full throughput of one request per cycle.
REQ-018 Winner selection SHALL be round-robin: search starts at (last_ptr+1) mod N_REQ, ascending with wrap, and picks the first i with s_valid[i]=1.
REQ-019 s_ready[i] SHALL be 1 only when load_ok=1 and i is the winner; at most one s_ready bit SHALL be high in any cycle, and s_ready SHALL be all-zero when no s_valid bit is set.
REQ-020 On an accept in cycle t, m_valid=1, m_data=s_data[winner] and m_id=winner SHALL be visible in cycle t+1, so input-to-output latency is exactly 1 cycle.
REQ-021 On an accept, last_ptr SHALL be set to the winner; with no accept, last_ptr SHALL hold.
REQ-022 While m_valid=1 and m_ready=0, m_data and m_id SHALL remain stable and m_valid SHALL stay high.
REQ-023 When m_ready=1 with no accept in the same cycle, m_valid SHALL go low the next cycle.
REQ-024 When m_ready=1 and an accept happen in the same cycle, the slot SHALL be replaced by the new request with no bubble.
REQ-025 When en=0, the held request SHALL still drain normally and no new request SHALL load.
REQ-026 grant_total SHALL increment by 1 on each input accept, wrapping from 0xFFFFFFFF to 0.
REQ-027 The block SHALL never inspect or modify descriptor contents; authorization is performed downstream.
REQ-028 Fairness bound: a requester holding s_valid=1 continuously with en=1 and m_ready=1 SHALL be accepted within N_REQ accepts.
REQ-029 The block SHALL generate no combinational path from s_data to s_ready; s_ready SHALL depend only on s_valid, en, m_valid, m_ready and last_ptr.

Reset
REQ-030 While areset=1, the block SHALL drive m_valid=0, m_data=0, m_id=0, grant_total=0, last_ptr=N_REQ-1 (so requester 0 is first in priority) and s_ready all-zero.
REQ-031 An areset asserted while a request is held SHALL discard that request; after release, no stale m_valid SHALL appear.

Verification
REQ-032 Scenario: N_REQ=4, all s_valid=1, m_ready=1, en=1 for 8 cycles after reset -> m_id sequence 0,1,2,3,0,1,2,3 on consecutive cycles and grant_total=8.
REQ-033 Scenario: only s_valid[2]=1 with data 0xABC and m_ready=0 for 5 cycles -> accept in cycle 0 only, m_data=0xABC and m_id=2 held stable for 5 cycles, s_ready=0 in cycles 1-4.
REQ-034 Scenario: m_valid=1 with m_ready=1 while s_valid[1]=1 -> same-cycle replace, m_valid stays 1, m_id changes to 1 with no bubble.
REQ-035 Scenario: en=0 while a request is held and s_valid=4'hF -> held request drains on m_ready, m_valid goes 0, no s_ready asserted until en=1.
REQ-036 Scenario: areset pulsed while holding m_id=3 -> next cycle m_valid=0 and grant_total=0; the first post-reset grant goes to requester 0 when all requesters are valid.
REQ-037 Scenario: grant_total preloaded to 0xFFFFFFFF (forced) followed by one accept -> grant_total=0; randomized m_ready backpressure -> no request lost or duplicated, checked by scoreboard.

Source files
------------

// File: rtl/gateway_req_arbiter.sv
// Round-robin arbiter that funnels N_REQ descriptor streams into one registered
// gateway request slot, tagging each forwarded descriptor with its requester ID.
module gateway_req_arbiter #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned DATA_W = 96,
  parameter int unsigned ID_W   = $clog2(N_REQ)
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    en,
  input  logic [N_REQ-1:0]        s_valid,
  output logic [N_REQ-1:0]        s_ready,
  input  logic [N_REQ*DATA_W-1:0] s_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [DATA_W-1:0]       m_data,
  output logic [ID_W-1:0]         m_id,
  output logic [31:0]             grant_total
);

  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [ID_W-1:0]   m_id_q, m_id_d;
  logic [ID_W-1:0]   last_ptr_q, last_ptr_d;
  logic [31:0]       grant_total_q, grant_total_d;

  logic            load_ok;
  logic            accept;
  logic            win_found;
  logic [ID_W-1:0] win_idx;
  logic [ID_W-1:0] cand;

  // The slot can take a new request when empty or when it drains this cycle.
  assign load_ok = en && (!m_valid_q || m_ready);

  // Search upward from the requester after the last winner, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = ID_W'((32'(last_ptr_q) + k) % N_REQ);
      if (!win_found && s_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign accept = load_ok && win_found && !areset;

  always_comb begin
    s_ready = '0;
    if (accept) begin
      s_ready[win_idx] = 1'b1;
    end
  end

  always_comb begin
    m_valid_d     = m_valid_q;
    m_data_d      = m_data_q;
    m_id_d        = m_id_q;
    last_ptr_d    = last_ptr_q;
    grant_total_d = grant_total_q;
    if (accept) begin
      m_valid_d     = 1'b1;
      m_data_d      = s_data[win_idx*DATA_W +: DATA_W];
      m_id_d        = win_idx;
      last_ptr_d    = win_idx;
      grant_total_d = grant_total_q + 32'd1;
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  // last_ptr resets to the top index so requester 0 has first priority.
  always_ff @(posedge aclk) begin
    if (areset) begin
      m_valid_q     <= 1'b0;
      m_data_q      <= '0;
      m_id_q        <= '0;
      last_ptr_q    <= ID_W'(N_REQ - 1);
      grant_total_q <= '0;
    end else begin
      m_valid_q     <= m_valid_d;
      m_data_q      <= m_data_d;
      m_id_q        <= m_id_d;
      last_ptr_q    <= last_ptr_d;
      grant_total_q <= grant_total_d;
    end
  end

  assign m_valid     = m_valid_q;
  assign m_data      = m_data_q;
  assign m_id        = m_id_q;
  assign grant_total = grant_total_q;

endmodule

// File: tb/tb_gateway_req_arbiter.sv
// Directed plus scoreboard-checked random bench for gateway_req_arbiter.
module tb_gateway_req_arbiter;

  localparam int unsigned N_REQ  = 4;
  localparam int unsigned DATA_W = 96;
  localparam int unsigned ID_W   = 2;

  logic                    aclk;
  logic                    areset;
  logic                    en;
  logic [N_REQ-1:0]        s_valid;
  logic [N_REQ-1:0]        s_ready;
  logic [N_REQ*DATA_W-1:0] s_data;
  logic                    m_valid;
  logic                    m_ready;
  logic [DATA_W-1:0]       m_data;
  logic [ID_W-1:0]         m_id;
  logic [31:0]             grant_total;

  int tests = 0;
  int fails = 0;

  gateway_req_arbiter #(
    .N_REQ (N_REQ),
    .DATA_W(DATA_W),
    .ID_W  (ID_W)
  ) dut (
    .aclk       (aclk),
    .areset     (areset),
    .en         (en),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_id       (m_id),
    .grant_total(grant_total)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [DATA_W-1:0] q_data[$];
  logic [ID_W-1:0]   q_id[$];
  int unsigned       mptr;
  int unsigned       nacc;
  logic              mvalid_m;
  logic              found;
  int unsigned       win;
  int unsigned       idx;
  logic [N_REQ-1:0]  exp_ready;

  initial begin
    areset  = 1'b1;
    en      = 1'b1;
    s_valid = 4'hF;
    m_ready = 1'b1;
    for (int i = 0; i < N_REQ; i++) s_data[i*DATA_W +: DATA_W] = DATA_W'(32'hD0 + i);

    // Reset state
    tick();
    tick();
    chk("rst_mvalid", m_valid, 0);
    chk("rst_mid", m_id, 0);
    chk("rst_mdata", m_data, 0);
    chk("rst_total", grant_total, 0);
    chk("rst_sready", s_ready, 0);

    // All requesters valid: rotating grants 0,1,2,3,...
    areset = 1'b0;
    #1;
    chk("rr_first_sready", s_ready, 4'b0001);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("rr_mvalid", m_valid, 1);
      chk("rr_mid", m_id, (k - 1) % 4);
      chk("rr_mdata", m_data, 32'hD0 + (k - 1) % 4);
      chk("rr_sready", s_ready, 4'b0001 << (k % 4));
    end
    chk("rr_total", grant_total, 8);

    // Drain with no new request
    s_valid = 4'b0000;
    #1;
    chk("idle_sready", s_ready, 0);
    tick();
    chk("drain_mvalid", m_valid, 0);

    // Single requester under backpressure: held stable
    s_valid = 4'b0100;
    m_ready = 1'b0;
    s_data[2*DATA_W +: DATA_W] = DATA_W'(32'hABC);
    #1;
    chk("bp_sready0", s_ready, 4'b0100);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_mvalid", m_valid, 1);
      chk("bp_mid", m_id, 2);
      chk("bp_mdata", m_data, 32'hABC);
      chk("bp_sready", s_ready, 0);
    end
    chk("bp_total", grant_total, 9);

    // Same-cycle replace with requester 1, no bubble
    m_ready = 1'b1;
    s_valid = 4'b0010;
    #1;
    chk("rep_sready", s_ready, 4'b0010);
    tick();
    chk("rep_mvalid", m_valid, 1);
    chk("rep_mid", m_id, 1);
    chk("rep_mdata", m_data, 32'hD1);
    chk("rep_total", grant_total, 10);

    // en low: held request drains, nothing loads
    en      = 1'b0;
    s_valid = 4'hF;
    #1;
    chk("en0_sready_a", s_ready, 0);
    tick();
    chk("en0_mvalid_a", m_valid, 0);
    chk("en0_sready_b", s_ready, 0);
    tick();
    chk("en0_mvalid_b", m_valid, 0);
    chk("en0_total", grant_total, 10);
    en = 1'b1;
    #1;
    chk("en1_sready", s_ready, 4'b0100);
    tick();
    chk("en1_mid", m_id, 2);
    chk("en1_mdata", m_data, 32'hABC);
    chk("en1_total", grant_total, 11);

    // Hold requester 3, then reset while it is held
    chk("r3_sready", s_ready, 4'b1000);
    tick();
    chk("r3_mid", m_id, 3);
    chk("r3_total", grant_total, 12);
    m_ready = 1'b0;
    #1;
    chk("r3_hold_sready", s_ready, 0);
    tick();
    chk("r3_hold_mid", m_id, 3);
    areset = 1'b1;
    tick();
    chk("mrst_mvalid", m_valid, 0);
    chk("mrst_total", grant_total, 0);
    chk("mrst_mid", m_id, 0);
    chk("mrst_mdata", m_data, 0);
    chk("mrst_sready", s_ready, 0);
    areset  = 1'b0;
    m_ready = 1'b1;
    #1;
    chk("post_rst_sready", s_ready, 4'b0001);
    tick();
    chk("post_rst_mid", m_id, 0);
    chk("post_rst_total", grant_total, 1);

    // Counter wrap from 0xFFFFFFFF
    s_valid = 4'b0000;
    tick();
    chk("wrap_pre_mvalid", m_valid, 0);
    force dut.grant_total_q = 32'hFFFF_FFFF;
    #1;
    release dut.grant_total_q;
    #1;
    chk("wrap_preload", grant_total, 32'hFFFF_FFFF);
    s_valid = 4'b0001;
    #1;
    chk("wrap_sready", s_ready, 4'b0001);
    tick();
    chk("wrap_total", grant_total, 0);
    chk("wrap_mid", m_id, 0);
    s_valid = 4'b0000;
    tick();
    chk("wrap_drain", m_valid, 0);

    // Random traffic against an independent round-robin model and scoreboard
    mptr = 0;
    nacc = 0;
    for (int c = 0; c < 400; c++) begin
      s_valid = 4'($urandom);
      m_ready = 1'($urandom);
      en      = ($urandom_range(0, 9) != 0);
      for (int i = 0; i < N_REQ; i++) begin
        s_data[i*DATA_W +: DATA_W] = {32'(i), 32'(c), 32'hA5A5_0000 + 32'(c)};
      end
      #1;
      mvalid_m = (q_data.size() != 0);
      chk("rnd_mvalid", m_valid, mvalid_m);
      found = 1'b0;
      win   = 0;
      for (int unsigned k = 1; k <= N_REQ; k++) begin
        idx = (mptr + k) % N_REQ;
        if (!found && s_valid[idx]) begin
          found = 1'b1;
          win   = idx;
        end
      end
      exp_ready = '0;
      if (en && (!mvalid_m || m_ready) && found) exp_ready[win] = 1'b1;
      chk("rnd_sready", s_ready, exp_ready);
      if (mvalid_m && m_ready) begin
        chk("rnd_mdata", m_data, q_data[0]);
        chk("rnd_mid", m_id, q_id[0]);
        void'(q_data.pop_front());
        void'(q_id.pop_front());
      end
      if (exp_ready != 0) begin
        q_data.push_back(s_data[win*DATA_W +: DATA_W]);
        q_id.push_back(ID_W'(win));
        mptr = win;
        nacc++;
      end
      tick();
    end

    // Drain the last held request and check totals
    s_valid = 4'b0000;
    m_ready = 1'b1;
    en      = 1'b1;
    #1;
    if (q_data.size() != 0) begin
      chk("fin_mdata", m_data, q_data[0]);
      chk("fin_mid", m_id, q_id[0]);
      void'(q_data.pop_front());
      void'(q_id.pop_front());
    end
    tick();
    chk("fin_mvalid", m_valid, 0);
    chk("fin_total", grant_total, nacc);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
